// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor (a - b - bin) built from two cascaded half subtractors.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic d1;
    logic bo1;
    logic bo2;

    half_subtractor u_hs_ab (
        .a    (a),
        .b    (b),
        .diff (d1),
        .bout (bo1)
    );

    half_subtractor u_hs_bin (
        .a    (d1),
        .b    (bin),
        .diff (diff),
        .bout (bo2)
    );

    assign bout = bo1 | bo2;

endmodule

// File: rtl/half_subtractor.sv
// One-bit half subtractor: diff = a - b, bout set when a borrow is needed.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b;
    assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b over WIDTH cycles, LSB first, one full_subtractor cell.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bin_q, bin_d;
    logic               borrow_q, borrow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cell_d;
    logic               cell_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bin_q),
        .diff (cell_d),
        .bout (cell_bout)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB so the last bit lands in place.
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bin_d = cell_bout;
                res_d = (res_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(WIDTH)) begin
                    state_d  = DONE;
                    diff_d   = res_d;
                    borrow_d = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 (directed + random) and WIDTH=4 (exhaustive).
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, busy8, done8, bor8;
    logic [7:0] a8, b8, diff8;
    logic       start4, busy4, done4, bor4;
    logic [3:0] a4, b4, diff4;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf4;
`endif

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bor8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (bor4)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf4)
`endif
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] last_diff8 = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input int w, input int unsigned a, input int unsigned b,
                                  output logic [31:0] d, output logic bo, output logic ov);
        longint full, half, la, lb, sa, sb, sd;
        full = longint'(1) << w;
        half = full / 2;
        la   = longint'(a);
        lb   = longint'(b);
        d    = 32'((la - lb + full) % full);
        bo   = (la < lb);
        sa   = (la >= half) ? la - full : la;
        sb   = (lb >= half) ? lb - full : lb;
        sd   = sa - sb;
        ov   = (sd < -half) || (sd >= half);
    endfunction

    // One WIDTH=8 operation: latency, busy, held result, outputs, single-cycle done.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [31:0] ed;
        logic        eb, eo;
        int          cyc;
        model(8, a, b, ed, eb, eo);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        cyc = 0;
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start8 = 1'b0;
                chk({tag, ".busy"}, 32'(busy8), 32'd1);
            end
            if (cyc == 5) chk({tag, ".hold"}, 32'(diff8), 32'(last_diff8));
        end
        chk({tag, ".lat"}, 32'(cyc), 32'd10);
        chk({tag, ".diff"}, 32'(diff8), ed);
        chk({tag, ".borrow"}, 32'(bor8), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, ".ovf"}, 32'(ovf8), 32'(eo));
`endif
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(done8), 32'd0);
        last_diff8 = ed[7:0];
    endtask

    initial begin
        int cyc;
        int pulses;
        logic [31:0] ed;
        logic eb, eo;

        rst = 1'b1; start8 = 1'b1; start4 = 1'b0;
        a8 = 8'hFF; b8 = 8'h01; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(busy8), 32'd0);
        chk("rst.done", 32'(done8), 32'd0);
        chk("rst.diff", 32'(diff8), 32'd0);
        chk("rst.borrow", 32'(bor8), 32'd0);
        start8 = 1'b0;
        rst = 1'b0;

        op8(8'h05, 8'h03, "d0");
        op8(8'h03, 8'h05, "d1");
        op8(8'h00, 8'hFF, "d2");
        op8(8'hA5, 8'hA5, "d3");
        op8(8'h80, 8'h01, "d4");
        op8(8'h7F, 8'hFF, "d5");
        op8(8'h10, 8'h01, "d6");
        for (int i = 0; i < 24; i++)
            op8(8'($urandom), 8'($urandom), $sformatf("r%0d", i));

        // Start pulsed mid-SHIFT must not disturb the running operation.
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start8 = 1'b0;
            if (c == 3) begin a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1; end
            if (c == 4) start8 = 1'b0;
            if (done8) begin
                pulses++;
                chk("ign.lat", 32'(c), 32'd10);
                chk("ign.diff", 32'(diff8), 32'h02);
                chk("ign.borrow", 32'(bor8), 32'd0);
            end
        end
        chk("ign.pulses", 32'(pulses), 32'd1);
        last_diff8 = 8'h02;

        // Reset mid-SHIFT aborts; reset wins over a simultaneous start.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h21; start8 = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start8 = 1'b0;
            if (c == 4) begin rst = 1'b1; start8 = 1'b1; end
            if (c == 5) begin
                rst = 1'b0; start8 = 1'b0;
                chk("abort.busy", 32'(busy8), 32'd0);
                chk("abort.done", 32'(done8), 32'd0);
                chk("abort.diff", 32'(diff8), 32'd0);
                chk("abort.borrow", 32'(bor8), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
                chk("abort.ovf", 32'(ovf8), 32'd0);
`endif
            end
            if (done8) pulses++;
        end
        chk("abort.pulses", 32'(pulses), 32'd0);
        last_diff8 = 8'h00;
        op8(8'h09, 8'h04, "post_rst");

        // Exhaustive WIDTH=4 with start held high: one result every WIDTH+2 cycles.
        @(negedge clk);
        a4 = 4'd0; b4 = 4'd0; start4 = 1'b1;
        for (int k = 0; k < 256; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done4 && cyc < 40);
            model(4, 32'(k >> 4), 32'(k & 15), ed, eb, eo);
            chk($sformatf("x4.%0d.lat", k), 32'(cyc), 32'd6);
            chk($sformatf("x4.%0d.diff", k), 32'(diff4), ed);
            chk($sformatf("x4.%0d.borrow", k), 32'(bor4), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("x4.%0d.ovf", k), 32'(ovf4), 32'(eo));
`endif
            a4 = 4'((k + 1) >> 4);
            b4 = 4'((k + 1) & 15);
            if (cyc >= 40) break;
        end
        start4 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
